// File: rtl/uart_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkt_fifo
//  Purpose  : Packet-aware byte FIFO placed behind an asynchronous UART
//             receiver. Received bytes are staged in a one-byte hold register
//             until it is known whether they end a packet (rx_eop arrives
//             after an idle gap). They are then pushed into a DEPTH x 9 FIFO
//             as {last, data} and presented on a first-word-fall-through
//             valid/ready stream.
//  Ports    :
//    clk           in   system clock
//    rst           in   asynchronous active-high reset
//    rx_ready      in   one-cycle strobe, rx_data valid
//    rx_data       in   [7:0] received byte
//    rx_eop        in   one-cycle end-of-packet strobe
//    out_valid     out  head entry valid (FIFO not empty)
//    out_data      out  [7:0] head byte
//    out_last      out  head byte is the last of its packet
//    out_ready     in   consumer accepts the head when out_valid
//    level         out  [AW:0] FIFO occupancy (hold register excluded)
//    hold_valid    out  a byte is held pending its last flag
//    overflow      out  sticky, a byte was dropped because the FIFO was full
//    overflow_clr  in   clears overflow (a same-cycle drop wins)
//    pkt_count     out  [15:0] completed packets accepted (wrapping)
//    drop_count    out  [7:0]  dropped bytes (saturating at 255)
//  Options  : define UART_RX_PKT_FIFO_STATS_EN to build the pkt_count and
//             drop_count counters; otherwise both ports are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_pkt_fifo #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_ready,
   input  logic [7:0]    rx_data,
   input  logic          rx_eop,
   output logic          out_valid,
   output logic [7:0]    out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          hold_valid,
   output logic          overflow,
   input  logic          overflow_clr,
   output logic [15:0]   pkt_count,
   output logic [7:0]    drop_count
);

   localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

   // Storage: {last, data}; contents intentionally not reset
   logic [8:0]    mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q,  level_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic          hold_valid_q, hold_valid_d;
   logic          overflow_q, overflow_d;

   logic          w_eop_push;
   logic          w_byte_push;
   logic          w_push_req;
   logic          w_push_last;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_drop;

   // ------------------------------------------------------------------------
   // Push / pop decisions
   // ------------------------------------------------------------------------
   // An end-of-packet strobe takes precedence over a same-cycle byte strobe:
   // the held byte is closed out as "last" and the new byte then becomes the
   // next held byte. Only one push can therefore happen per cycle.
   assign w_eop_push  = rx_eop && hold_valid_q;
   assign w_byte_push = rx_ready && hold_valid_q && !rx_eop;
   assign w_push_req  = w_eop_push || w_byte_push;
   assign w_push_last = w_eop_push;

   assign w_full  = (level_q == C_FULL_LEVEL);
   assign w_empty = (level_q == '0);
   assign w_pop   = !w_empty && out_ready;

   // When full, a push only fits if the head leaves in the same cycle.
   assign w_push_ok = w_push_req && (!w_full || w_pop);
   assign w_drop    = w_push_req && w_full && !w_pop;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      overflow_d   = overflow_q;

      if (w_push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({w_push_ok, w_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // The hold register updates regardless of whether the push was dropped.
      if (rx_ready) begin
         hold_data_d  = rx_data;
         hold_valid_d = 1'b1;
      end else if (w_eop_push) begin
         hold_valid_d = 1'b0;
      end

      // Set has priority over clear so a drop in the clearing cycle is kept.
      if (w_drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         mem_q[wr_ptr_q] <= {w_push_last, hold_data_q};
      end
   end

   // ------------------------------------------------------------------------
   // Optional statistics counters
   // ------------------------------------------------------------------------
`ifdef UART_RX_PKT_FIFO_STATS_EN
   logic [15:0] pkt_count_q, pkt_count_d;
   logic [7:0]  drop_count_q, drop_count_d;

   always_comb begin
      pkt_count_d  = pkt_count_q;
      drop_count_d = drop_count_q;
      // Only packets whose final byte made it into the FIFO are counted.
      if (w_push_ok && w_push_last) begin
         pkt_count_d = pkt_count_q + 16'd1;
      end
      if (w_drop && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;
`else
   assign pkt_count  = '0;
   assign drop_count = '0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // First-word-fall-through: the head is read combinationally.
   assign out_valid  = !w_empty;
   assign out_data   = mem_q[rd_ptr_q][7:0];
   assign out_last   = mem_q[rd_ptr_q][8];
   assign level      = level_q;
   assign hold_valid = hold_valid_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_pkt_fifo
//  Purpose  : Self-checking bench for uart_rx_pkt_fifo: a directed vector
//             table, hand-written corner sequences and randomized traffic,
//             all compared against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_pkt_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_ready;
   logic [7:0]    rx_data;
   logic          rx_eop;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_last;
   logic          out_ready;
   logic [AW:0]   level;
   logic          hold_valid;
   logic          overflow;
   logic          overflow_clr;
   logic [15:0]   pkt_count;
   logic [7:0]    drop_count;

   uart_rx_pkt_fifo #(.DEPTH(DEPTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_eop       (rx_eop),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .level        (level),
      .hold_valid   (hold_valid),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .pkt_count    (pkt_count),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- reference model ----------------
   logic [8:0]  m_q[$];
   logic [7:0]  m_hold;
   bit          m_hv;
   bit          m_ovf;
   int unsigned m_pkt;
   int unsigned m_drop;

`ifdef UART_RX_PKT_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   task automatic model_reset();
      m_q.delete();
      m_hv   = 1'b0;
      m_hold = '0;
      m_ovf  = 1'b0;
      m_pkt  = 0;
      m_drop = 0;
   endtask

   // One clock edge worth of behaviour, from the packet rules.
   task automatic model_step(input bit rdy, input logic [7:0] d, input bit eop,
                             input bit ordy, input bit clr);
      bit         pop;
      bit         preq;
      bit         fits;
      logic [8:0] ent;
      pop  = (m_q.size() != 0) && ordy;
      preq = 1'b0;
      ent  = '0;
      if (eop && m_hv) begin
         preq = 1'b1;
         ent  = {1'b1, m_hold};
      end else if (rdy && m_hv) begin
         preq = 1'b1;
         ent  = {1'b0, m_hold};
      end
      fits = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (preq && fits) begin
         m_q.push_back(ent);
         if (ent[8]) m_pkt = (m_pkt + 1) % 65536;
      end
      if (preq && !fits) begin
         m_ovf = 1'b1;
         if (m_drop < 255) m_drop++;
      end else if (clr) begin
         m_ovf = 1'b0;
      end
      if (rdy) begin
         m_hold = d;
         m_hv   = 1'b1;
      end else if (eop) begin
         m_hv = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("m.out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("m.out_data", 32'(out_data), 32'(m_q[0][7:0]));
         chk("m.out_last", 32'(out_last), 32'(m_q[0][8]));
      end
      chk("m.level",      32'(level),      32'(m_q.size()));
      chk("m.hold_valid", 32'(hold_valid), 32'(m_hv));
      chk("m.overflow",   32'(overflow),   32'(m_ovf));
      chk("m.pkt_count",  32'(pkt_count),  STATS ? 32'(m_pkt)  : 32'd0);
      chk("m.drop_count", 32'(drop_count), STATS ? 32'(m_drop) : 32'd0);
   endtask

   // Called just after a negedge: drive, let one posedge happen, check at
   // the following negedge.
   task automatic cycle(input bit rdy, input logic [7:0] d, input bit eop,
                        input bit ordy, input bit clr);
      rx_ready     = rdy;
      rx_data      = d;
      rx_eop       = eop;
      out_ready    = ordy;
      overflow_clr = clr;
      model_step(rdy, d, eop, ordy, clr);
      @(posedge clk);
      @(negedge clk);
      rx_ready     = 1'b0;
      rx_eop       = 1'b0;
      overflow_clr = 1'b0;
      check_model();
   endtask

   typedef struct {
      bit         rdy;
      logic [7:0] d;
      bit         eop;
      bit         ordy;
      bit         ev;
      logic [7:0] ed;
      bit         el;
      int         elvl;
      bit         eh;
   } vec_t;

   vec_t vecs[5];

   initial begin
      // Single packet 0x41 0x42 0x43 + eop with the consumer always ready.
      vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
      vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1, 1'b1};
      vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1, 1'b1};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h43, 1'b1, 1, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};

      rst = 1'b1; rx_ready = 1'b0; rx_data = '0; rx_eop = 1'b0;
      out_ready = 1'b0; overflow_clr = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.level",     32'(level),     32'd0);
      chk("reset.hold",      32'(hold_valid),32'd0);
      chk("reset.overflow",  32'(overflow),  32'd0);
      chk("reset.pkt",       32'(pkt_count), 32'd0);
      chk("reset.drop",      32'(drop_count),32'd0);
      rst = 1'b0;

      // ---- table-driven single packet ----
      for (int i = 0; i < 5; i++) begin
         cycle(vecs[i].rdy, vecs[i].d, vecs[i].eop, vecs[i].ordy, 1'b0);
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(vecs[i].ed));
            chk($sformatf("vec%0d.last", i), 32'(out_last), 32'(vecs[i].el));
         end
         chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].elvl));
         chk($sformatf("vec%0d.hold", i), 32'(hold_valid), 32'(vecs[i].eh));
      end
      chk("pkt.single", 32'(pkt_count), STATS ? 32'd1 : 32'd0);

      // ---- holdback ----
      cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 1000; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("hold.valid_low", 32'(out_valid), 32'd0);
      chk("hold.held",      32'(hold_valid), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.out_data",  32'(out_data),  32'h55);
      chk("hold.out_last",  32'(out_last),  32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // ---- overflow: 18 bytes + eop with consumer stalled ----
      for (int i = 0; i < 18; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("ovf.level",    32'(level),      32'd16);
      chk("ovf.flag",     32'(overflow),   32'd1);
      chk("ovf.drop",     32'(drop_count), STATS ? 32'd2 : 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("ovf.rd_data", 32'(out_data), 32'(i));
         chk("ovf.rd_last", 32'(out_last), 32'd0);
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      chk("ovf.empty", 32'(out_valid), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf.cleared", 32'(overflow), 32'd0);

      // ---- simultaneous push/pop at full across pointer wrap ----
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
      chk("bp.full", 32'(level), 32'd16);
      cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      chk("bp.level",  32'(level),      32'd16);
      chk("bp.noovf",  32'(overflow),   32'd0);
      chk("bp.drop",   32'(drop_count), STATS ? 32'd2 : 32'd0);
      for (int i = 1; i <= 16; i++) begin
         chk("bp.order", 32'(out_data), 32'h20 + 32'(i));
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("bp.tail_data", 32'(out_data), 32'h77);
      chk("bp.tail_last", 32'(out_last), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // ---- edge strobes ----
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("edge.empty_eop", 32'(level), 32'd0);
      cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      chk("edge.level", 32'(level),      32'd1);
      chk("edge.data",  32'(out_data),   32'h10);
      chk("edge.last",  32'(out_last),   32'd1);
      chk("edge.hold",  32'(hold_valid), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("edge.next",  32'(out_data),   32'h99);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // ---- async reset mid-packet ----
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("arst.valid", 32'(out_valid),  32'd0);
      chk("arst.level", 32'(level),      32'd0);
      chk("arst.hold",  32'(hold_valid), 32'd0);
      #1 rst = 1'b0;
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("arst.data", 32'(out_data), 32'hA5);
      chk("arst.last", 32'(out_last), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         bit rdy, eop, ordy, clr;
         rdy  = ($urandom_range(0, 99) < 45);
         eop  = ($urandom_range(0, 99) < 12);
         ordy = (i % 600 < 300) ? ($urandom_range(0, 99) < 30)
                                : ($urandom_range(0, 99) < 70);
         clr  = ($urandom_range(0, 99) < 3);
         cycle(rdy, 8'($urandom), eop, ordy, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_pkt_fifo.md
Name: uart_rx_pkt_fifo

Overview:
- Sits directly downstream of the async UART receiver.
- Consumes its one-cycle byte strobe (rx_ready/rx_data) and its end-of-packet strobe (rx_eop, issued after an idle gap).
- Buffers bytes in a FIFO and presents them as a valid/ready byte stream with a per-byte "last" flag marking packet boundaries.
- Because rx_eop arrives some time after the final byte, the newest byte is held back until its last-ness is known.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, >= 2; AW = log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_ready  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- rx_eop  in  1  one-cycle end-of-packet strobe
- out_valid  out  1  out_data/out_last valid
- out_data  out  8  head byte
- out_last  out  1  head byte is last of packet
- out_ready  in  1  consumer accepts head when out_valid
- level  out  AW+1  FIFO occupancy, excluding hold register
- hold_valid  out  1  a byte is held pending its last flag
- overflow  out  1  sticky: a byte was dropped on full
- overflow_clr  in  1  clears overflow
- pkt_count  out  16  packets completed (see Optional Feature)
- drop_count  out  8  bytes dropped (see Optional Feature)

Behaviour:
- Reset (async, rst=1): rd/wr pointers 0, level=0, out_valid=0, hold_valid=0, overflow=0, pkt_count=0, drop_count=0. Memory contents are not reset. out_data/out_last are don't-care while out_valid=0.
- Storage: DEPTH x 9 bits {last, data}. Hold register: 8-bit data plus hold_valid.
- Push source: hold register only. At most one push per cycle.
- rx_ready=1, hold_valid=0: rx_data loads into hold; hold_valid<=1; no push.
- rx_ready=1, hold_valid=1: push {0, hold}; rx_data loads into hold.
- rx_eop=1, hold_valid=1, rx_ready=0: push {1, hold}; hold_valid<=0.
- rx_eop=1, hold_valid=0: ignored (empty packet); no push, no count.
- rx_eop=1 and rx_ready=1 same cycle: eop applies first. Push {1, hold} if hold_valid; then rx_data loads into hold; hold_valid<=1.
- Pop: out_valid && out_ready advances rd_ptr. out_valid = (level != 0).
  - Head read is first-word-fall-through, combinational from mem[rd_ptr].
  - Latency: a pushed entry is visible on out_valid the cycle after the push edge.
- Full (level==DEPTH): a push is accepted only if a pop occurs in the same cycle; otherwise:
  - the pushed entry is discarded;
  - overflow<=1;
  - drop_count increments;
  - the hold register still updates as specified.
- Empty, push and pop requested same cycle: no pop (out_valid=0); push proceeds.
- Pointers are AW bits and wrap modulo DEPTH. level updates +1 on push only, -1 on pop only, unchanged on both.
- overflow_clr=1 clears overflow. If a drop occurs in the same cycle, set wins (overflow=1).
- Inputs are already in the clk domain; no input synchronisation.
- Reset asserted mid-packet discards the FIFO and hold contents; no partial output after release.

Optional Feature:
- Macro: UART_RX_PKT_FIFO_STATS_EN.
- Defined:
  - pkt_count increments by 1 on every accepted push with last=1; wraps at 16 bits.
  - drop_count increments on every dropped push; saturates at 255.
  - Both clear on rst.
- Undefined: pkt_count and drop_count are tied to 0 and no counter logic is built. Ports remain present; all other behaviour is identical.

Test Plan:
- Single packet: bytes 0x41, 0x42, 0x43 via rx_ready strobes, then rx_eop; out_ready=1 → out stream 0x41/last0, 0x42/last0, 0x43/last1; hold_valid=1 between the strobes; level returns to 0; pkt_count=1 (STATS_EN).
- Holdback: byte 0x55 then no rx_eop for 1000 cycles → out_valid stays 0, hold_valid=1; rx_eop → out 0x55/last1 the cycle after the push edge.
- Overflow: DEPTH=16, out_ready=0, 18 bytes + eop → level=16; overflow=1; drop_count=2; bytes 0..15 read back intact with last=0; overflow_clr → overflow=0.
- Backpressure with simultaneous push/pop at full: level=16, out_ready=1 during one push → no drop; level stays 16; order preserved across pointer wrap.
- Edge strobes: rx_eop with hold empty → no push; rx_eop and rx_ready of 0x99 in the same cycle with 0x10 held → 0x10/last1 pushed, 0x99 held.
- Async reset mid-packet: rst pulse (no clk edge) after 3 bytes → out_valid=0, level=0, hold_valid=0 immediately; next packet 0xA5 + eop → 0xA5/last1.
